// File: rtl/ftdi_pkg.sv
// Shared constants and FSM encoding for the FTDI TX arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ftdi_pkg;

    // First byte of every inserted header beat
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/ftdi_tx_arbiter_rr_pick.sv
// Round-robin picker: first requesting channel searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [2:0]      i_last,
    output logic [2:0]      o_grant,
    output logic            o_any
);

    int w_dist;
    int w_best;

    // Pick the requester with the smallest rotational distance after i_last
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_best  = N_CH;
        w_dist  = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + 2 * N_CH - 1 - int'(i_last)) % N_CH;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_grant = 3'(i);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Packet-atomic round-robin merge of N_CH AXI4-Stream channels, optional header beat per packet.
// Latency: combinational data path; one IDLE decision cycle between packets, plus one header beat.
// Backpressure: m_axis_tready gates the header and is passed straight to the granted channel only.
module ftdi_tx_arbiter
    import ftdi_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_BYTES = 4,
    parameter int HDR_EN     = 1
) (
    input  logic                         tx_clk,
    input  logic                         rst_txclk,
    input  logic [N_CH-1:0]              ch_en,
    input  logic [N_CH-1:0]              s_axis_tvalid,
    output logic [N_CH-1:0]              s_axis_tready,
    input  logic [N_CH*DATA_BYTES*8-1:0] s_axis_tdata,
    input  logic [N_CH*DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic [N_CH-1:0]              s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_BYTES*8-1:0]      m_axis_tdata,
    output logic [DATA_BYTES-1:0]        m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic [2:0]                   grant_id,
    output logic                         pkt_done
);

    localparam int DW = DATA_BYTES * 8;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_grant;
    logic [2:0]           r_last_grant;
    logic [2:0]           w_pick;
    logic                 w_any;
    logic [N_CH-1:0]      w_req;
    logic                 w_sel_vld;
    logic                 w_sel_last;
    logic [DW-1:0]        w_sel_data;
    logic [DATA_BYTES-1:0] w_sel_keep;
    logic [DW-1:0]        w_hdr;
    logic                 w_done;

    // Disabled channels never enter arbitration, even while valid
    assign w_req = s_axis_tvalid & ch_en;

    rr_pick #(
        .N_CH(N_CH)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // Select the granted channel's stream signals
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        w_sel_keep = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_grant == 3'(i)) begin
                w_sel_vld  = s_axis_tvalid[i];
                w_sel_last = s_axis_tlast[i];
                w_sel_data = s_axis_tdata[i*DW +: DW];
                w_sel_keep = s_axis_tkeep[i*DATA_BYTES +: DATA_BYTES];
            end
        end
    end

    // Header beat: magic, then granted channel index, rest zero
    always_comb begin
        w_hdr       = '0;
        w_hdr[7:0]  = HDR_MAGIC;
        w_hdr[15:8] = {5'd0, r_grant};
    end

    // Next state and stream outputs; nothing is driven in IDLE
    always_comb begin
        w_next        = r_state;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = (HDR_EN != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w_hdr;
                m_axis_tkeep  = '1;
                if (m_axis_tready) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axis_tvalid = w_sel_vld;
                m_axis_tdata  = w_sel_data;
                m_axis_tkeep  = w_sel_keep;
                m_axis_tlast  = w_sel_last;
                for (int i = 0; i < N_CH; i++) begin
                    s_axis_tready[i] = m_axis_tready && (r_grant == 3'(i));
                end
                // Only tlast ends a grant; ch_en changes are ignored here
                if (w_sel_vld && m_axis_tready && w_sel_last) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, latched grant and round-robin pointer
    always_ff @(posedge tx_clk) begin
        if (rst_txclk) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= 3'(N_CH - 1);
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant <= w_pick;
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant;
    assign pkt_done = w_done;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Randomized scoreboard bench for ftdi_tx_arbiter (header and header-less instances).
// Latency: checks one decision cycle between back-to-back packets.
// Backpressure: m_axis_tready driven always-on, random, or toggling.
module tb_ftdi_tx_arbiter;
    import ftdi_pkg::*;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int DW = DB * 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
        logic [2:0]    ch;
        logic          hdr;
    } exp_t;

    logic tx_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 tx_clk = ~tx_clk;

    // Instance A: header enabled
    logic [N-1:0]    ch_en, s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*DB-1:0] s_tkeep;
    logic            m_tvalid, m_tready, m_tlast, busy, pkt_done;
    logic [DW-1:0]   m_tdata;
    logic [DB-1:0]   m_tkeep;
    logic [2:0]      grant_id;

    // Instance B: header disabled
    logic [N-1:0]    b_ch_en, b_s_tvalid, b_s_tready, b_s_tlast;
    logic [N*DW-1:0] b_s_tdata;
    logic [N*DB-1:0] b_s_tkeep;
    logic            b_m_tvalid, b_m_tready, b_m_tlast, b_busy, b_pkt_done;
    logic [DW-1:0]   b_m_tdata;
    logic [DB-1:0]   b_m_tkeep;
    logic [2:0]      b_grant_id;

    ftdi_tx_arbiter #(.N_CH(N), .DATA_BYTES(DB), .HDR_EN(1)) dut_a (
        .tx_clk(tx_clk), .rst_txclk(rst), .ch_en(ch_en),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .busy(busy), .grant_id(grant_id), .pkt_done(pkt_done)
    );

    ftdi_tx_arbiter #(.N_CH(N), .DATA_BYTES(DB), .HDR_EN(0)) dut_b (
        .tx_clk(tx_clk), .rst_txclk(rst), .ch_en(b_ch_en),
        .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata),
        .s_axis_tkeep(b_s_tkeep), .s_axis_tlast(b_s_tlast),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tdata(b_m_tdata),
        .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
        .busy(b_busy), .grant_id(b_grant_id), .pkt_done(b_pkt_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Source queues (driven), model copies, expectations
    beat_t chq [N][$];
    beat_t mq  [N][$];
    exp_t  exp_q[$];
    beat_t bq[$];
    exp_t  expb_q[$];
    logic [2:0] hdr_order[$];
    int model_last = N - 1;
    int rdy_mode   = 0;
    int acc_data   = 0;
    int done_cnt   = 0;
    int b_beats    = 0;

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic add_pkt(input int ch, input int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = $urandom;
            b.keep = (j == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
            b.last = (j == len - 1);
            chq[ch].push_back(b);
            mq[ch].push_back(b);
        end
    endtask

    // Reference: round-robin over channels with pending packets, whole packets at a time
    task automatic model_run(input logic [N-1:0] en);
        int   c;
        bit   found;
        exp_t e;
        beat_t b;
        do begin
            found = 0;
            c = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && en[(model_last + k) % N] && mq[(model_last + k) % N].size() > 0) begin
                    found = 1;
                    c = (model_last + k) % N;
                end
            end
            if (found) begin
                e.data = {16'h0, 5'd0, 3'(c), HDR_MAGIC};
                e.keep = '1; e.last = 1'b0; e.ch = 3'(c); e.hdr = 1'b1;
                exp_q.push_back(e);
                do begin
                    b = mq[c].pop_front();
                    e.data = b.data; e.keep = b.keep; e.last = b.last; e.ch = 3'(c); e.hdr = 1'b0;
                    exp_q.push_back(e);
                end while (!b.last);
                model_last = c;
            end
        end while (found);
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) begin
            chq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
    endtask

    task automatic wait_drain(input int max);
        int t = 0;
        while (exp_q.size() > 0 && t < max) begin
            step();
            t++;
        end
        chk("drain_in_time", 64'(exp_q.size()), 64'd0);
        repeat (2) step();
        flush_all();
        repeat (2) step();
    endtask

    task automatic wait_beats(input int target, input int max);
        int t = 0;
        while (acc_data < target && t < max) begin
            step();
            t++;
        end
        chk("beats_reached", 64'(acc_data >= target), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        flush_all();
        model_last = N - 1;
    endtask

    // Driver A: advance each channel after a handshake, then re-present its head beat
    logic [N-1:0] hs_a;
    initial begin
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 1'b1;
        forever begin
            @(negedge tx_clk);
            hs_a = s_tvalid & s_tready & {N{!rst}};
            @(posedge tx_clk);
            #1;
            for (int i = 0; i < N; i++)
                if (hs_a[i] && chq[i].size() > 0) void'(chq[i].pop_front());
            #1;
            for (int i = 0; i < N; i++) begin
                if (chq[i].size() > 0) begin
                    s_tvalid[i]            = 1'b1;
                    s_tdata[i*DW +: DW]    = chq[i][0].data;
                    s_tkeep[i*DB +: DB]    = chq[i][0].keep;
                    s_tlast[i]             = chq[i][0].last;
                end else begin
                    s_tvalid[i]            = 1'b0;
                    s_tdata[i*DW +: DW]    = '0;
                    s_tkeep[i*DB +: DB]    = '0;
                    s_tlast[i]             = 1'b0;
                end
            end
            case (rdy_mode)
                1:       m_tready = ($urandom_range(0, 3) != 0);
                2:       m_tready = ~m_tready;
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Monitor A: scoreboard pop, stall stability, single-cycle gap between packets
    exp_t cur;
    logic prev_stall = 1'b0, chk_idle = 1'b0, chk_resume = 1'b0;
    logic [DW+DB:0] prev_out;
    always @(negedge tx_clk) begin
        if (rst) begin
            prev_stall = 1'b0; chk_idle = 1'b0; chk_resume = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", 64'(m_tvalid), 64'd1);
                chk("stall_outputs_held", 64'({m_tdata, m_tkeep, m_tlast}), 64'(prev_out));
            end
            if (chk_resume) begin
                chk("gap_resume_valid", 64'(m_tvalid), 64'd1);
                chk_resume = 1'b0;
            end
            if (chk_idle) begin
                chk("gap_idle_busy_valid", 64'({busy, m_tvalid}), 64'd0);
                chk_idle = 1'b0;
                chk_resume = 1'b1;
            end
            if (pkt_done) done_cnt++;
            if (m_tvalid) chk("busy_while_valid", 64'(busy), 64'd1);
            if (m_tvalid && m_tready) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("beat_data", 64'(m_tdata), 64'(cur.data));
                    chk("beat_keep", 64'(m_tkeep), 64'(cur.keep));
                    chk("beat_last", 64'(m_tlast), 64'(cur.last));
                    chk("grant_id", 64'(grant_id), 64'(cur.ch));
                    chk("pkt_done_on_last", 64'(pkt_done), 64'(cur.last));
                    if (cur.hdr) hdr_order.push_back(m_tdata[10:8]);
                    else acc_data++;
                    if (cur.last && exp_q.size() > 0) chk_idle = 1'b1;
                end
            end else begin
                chk("pkt_done_quiet", 64'(pkt_done), 64'd0);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tdata, m_tkeep, m_tlast};
        end
    end

    // Driver B: channel 1 only, sink always ready
    logic hs_b;
    initial begin
        b_ch_en = '1; b_s_tvalid = '0; b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = '0; b_m_tready = 1'b1;
        forever begin
            @(negedge tx_clk);
            hs_b = b_s_tvalid[1] & b_s_tready[1] & !rst;
            @(posedge tx_clk);
            #1;
            if (hs_b && bq.size() > 0) void'(bq.pop_front());
            #1;
            b_s_tvalid[1]      = (bq.size() > 0);
            b_s_tdata[DW +: DW] = (bq.size() > 0) ? bq[0].data : '0;
            b_s_tkeep[DB +: DB] = (bq.size() > 0) ? bq[0].keep : '0;
            b_s_tlast[1]       = (bq.size() > 0) ? bq[0].last : 1'b0;
        end
    end

    // Monitor B
    exp_t curb;
    logic b_chk_idle = 1'b0, b_chk_resume = 1'b0;
    always @(negedge tx_clk) begin
        if (rst) begin
            b_chk_idle = 1'b0; b_chk_resume = 1'b0;
        end else begin
            if (b_chk_resume) begin
                chk("b_gap_resume_valid", 64'(b_m_tvalid), 64'd1);
                b_chk_resume = 1'b0;
            end
            if (b_chk_idle) begin
                chk("b_gap_idle_valid", 64'({b_busy, b_m_tvalid}), 64'd0);
                b_chk_idle = 1'b0;
                b_chk_resume = 1'b1;
            end
            if (b_m_tvalid && b_m_tready) begin
                chk("b_beat_expected", 64'(expb_q.size() != 0), 64'd1);
                if (expb_q.size() != 0) begin
                    curb = expb_q.pop_front();
                    chk("b_beat_data", 64'(b_m_tdata), 64'(curb.data));
                    chk("b_beat_last", 64'(b_m_tlast), 64'(curb.last));
                    chk("b_grant_id", 64'(b_grant_id), 64'(curb.ch));
                    chk("b_pkt_done", 64'(b_pkt_done), 64'(curb.last));
                    b_beats++;
                    if (curb.last && expb_q.size() > 0) b_chk_idle = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, t;
        exp_t e;
        beat_t b;
        logic [N-1:0] en;
        logic [2:0] want [6];
        ch_en = '1;
        repeat (3) step();
        @(negedge tx_clk);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Two pending 3-beat packets right after reset: ch0 then ch2
        rdy_mode = 0;
        d0 = done_cnt;
        hdr_order.delete();
        add_pkt(0, 3);
        add_pkt(2, 3);
        model_run(4'hF);
        wait_drain(200);
        chk("two_pkt_done_count", 64'(done_cnt - d0), 64'd2);
        chk("two_pkt_first_grant", 64'(hdr_order.size() > 0 ? hdr_order[0] : 3'd7), 64'd0);
        chk("two_pkt_second_grant", 64'(hdr_order.size() > 1 ? hdr_order[1] : 3'd7), 64'd2);

        // All channels valid, 1-beat packets: strict rotation from channel 0
        do_reset();
        step();
        rdy_mode = 1;
        hdr_order.delete();
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 1);
            add_pkt(i, 1);
        end
        model_run(4'hF);
        wait_drain(400);
        want[0] = 3'd0; want[1] = 3'd1; want[2] = 3'd2;
        want[3] = 3'd3; want[4] = 3'd0; want[5] = 3'd1;
        for (int i = 0; i < 6; i++)
            chk("rotation_order", 64'(hdr_order.size() > i ? hdr_order[i] : 3'd7), 64'(want[i]));

        // 5-beat packet under toggling back-pressure
        rdy_mode = 2;
        a0 = acc_data;
        add_pkt(3, 5);
        model_run(4'hF);
        wait_drain(200);
        chk("toggle_data_beats", 64'(acc_data - a0), 64'd5);

        // Ch1 8-beat packet; ch0 arrives and ch1 is disabled at beat 3
        rdy_mode = 1;
        add_pkt(1, 8);
        model_run(4'hF);
        wait_beats(acc_data + 3, 200);
        ch_en[1] = 1'b0;
        add_pkt(0, 2);
        add_pkt(1, 3);
        model_run(4'b1101);
        wait_drain(300);
        ch_en = '1;
        step();

        // Reset at beat 2 of 4 abandons the packet
        rdy_mode = 0;
        add_pkt(1, 4);
        model_run(4'hF);
        wait_beats(acc_data + 2, 200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush_all();
        model_last = N - 1;
        @(negedge tx_clk);
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
        step();
        hdr_order.delete();
        for (int i = N - 1; i >= 0; i--) add_pkt(i, 2);
        model_run(4'hF);
        wait_drain(300);
        chk("post_rst_first_grant", 64'(hdr_order.size() > 0 ? hdr_order[0] : 3'd7), 64'd0);

        // Randomized phases
        for (int p = 0; p < 10; p++) begin
            en = 4'($urandom);
            ch_en = en;
            rdy_mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                t = $urandom_range(0, 3);
                for (int k = 0; k < t; k++) add_pkt(i, $urandom_range(1, 5));
            end
            model_run(en);
            wait_drain(1000);
            ch_en = '1;
            step();
        end

        // Header-less instance: two 2-beat packets back to back on ch1
        for (int k = 0; k < 4; k++) begin
            b.data = $urandom; b.keep = 4'hF; b.last = (k % 2 == 1);
            bq.push_back(b);
            e.data = b.data; e.keep = b.keep; e.last = b.last; e.ch = 3'd1; e.hdr = 1'b0;
            expb_q.push_back(e);
        end
        t = 0;
        while (expb_q.size() > 0 && t < 100) begin
            step();
            t++;
        end
        chk("b_drain_in_time", 64'(expb_q.size()), 64'd0);
        chk("b_data_beats", 64'(b_beats), 64'd4);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ftdi_tx_arbiter.md
FTDI_TX_ARBITER -- requirements
Module: ftdi_tx_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of requesting AXI4-Stream channels (2-8).
REQ-002 SHALL have parameter DATA_BYTES, default 4, meaning tdata width in bytes of every port (2-64), equal to the downstream width-converter input.
REQ-003 SHALL have parameter HDR_EN, default 1, meaning whether one header beat is inserted before each packet (1) or not (0).
REQ-004 SHALL have ports: tx_clk  in  1  block clock; rst_txclk  in  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have ports: ch_en  in  N_CH  per-channel arbitration enable.
REQ-006 SHALL have ports: s_axis_tvalid  in  N_CH;  s_axis_tready  out  N_CH;  s_axis_tdata  in  N_CH*DATA_BYTES*8;  s_axis_tkeep  in  N_CH*DATA_BYTES;  s_axis_tlast  in  N_CH; channel i occupies slice i of each bus.
REQ-007 SHALL have ports: m_axis_tvalid  out  1;  m_axis_tready  in  1;  m_axis_tdata  out  DATA_BYTES*8;  m_axis_tkeep  out  DATA_BYTES;  m_axis_tlast  out  1.
REQ-008 SHALL have ports: busy  out  1  packet in progress; grant_id  out  3  currently/last granted channel; pkt_done  out  1  one-cycle pulse on final beat of each packet.

Function
REQ-009 SHALL implement states IDLE, HDR, DATA.
REQ-010 In IDLE, requester set = s_axis_tvalid & ch_en; if nonzero SHALL latch grant = first set bit searching upward from (last_grant+1) mod N_CH, wrapping; next state HDR if HDR_EN=1 else DATA.
REQ-011 IDLE with empty requester set SHALL stay IDLE; all outputs deasserted.
REQ-012 In HDR: m_axis_tvalid=1, tdata byte0=8'hA5, byte1=grant index, other bytes 0, tkeep all ones, tlast=0; all s_axis_tready=0; on m_axis_tready go DATA.
REQ-013 In DATA: m_axis_tvalid/tdata/tkeep/tlast = granted channel's signals; s_axis_tready[grant]=m_axis_tready; all other tready=0.
REQ-014 DATA beat with tvalid&tready&tlast SHALL: pulse pkt_done, set last_grant=grant, go IDLE.
REQ-015 Arbitration SHALL be packet-atomic: no channel switch before tlast regardless of other requests.
REQ-016 ch_en deassertion of the granted channel mid-packet SHALL NOT abort the packet; it only excludes the channel at the next IDLE decision.
REQ-017 Gap between packets SHALL be exactly one IDLE cycle (decision cycle); header adds one beat when HDR_EN=1.
REQ-018 Back-pressure (m_axis_tready=0) in HDR or DATA SHALL hold all m_axis outputs stable and state unchanged.
REQ-019 busy SHALL be 1 in HDR and DATA, 0 in IDLE; grant_id SHALL hold the latched grant (zero-extended) until the next decision.
REQ-020 Single requester SHALL be granted back-to-back packets with only the REQ-017 gap.

Reset
REQ-021 rst_txclk=1 at a tx_clk edge SHALL force state IDLE, last_grant=N_CH-1 (so channel 0 wins first), grant_id=0, busy=0, pkt_done=0, m_axis_tvalid=0, all s_axis_tready=0.
REQ-022 Reset mid-packet SHALL abandon the packet without emitting tlast; no partial-beat recovery is required.

Structure
REQ-023 Header magic 8'hA5 and state encoding SHALL live in shared package ftdi_pkg.
REQ-024 Round-robin next-grant logic SHALL be sub-module rr_pick (request vector, last grant -> grant index, any-request flag), purely combinational.
REQ-025 Output SHALL connect directly to the TX width converter s_axis port; no internal buffering.

Verification
REQ-026 Ch0 and ch2 both pending 3-beat packets after reset, HDR_EN=1 -> header 0xA5/0x00, ch0 beats, IDLE cycle, header 0xA5/0x02, ch2 beats; pkt_done pulses twice.
REQ-027 All 4 channels continuously valid, 1-beat packets -> grant order 0,1,2,3,0,1 with no repeats.
REQ-028 Ch1 mid 8-beat packet, ch0 asserts valid and ch1 ch_en drops at beat 3 -> ch1 completes all 8 beats, then ch0 granted.
REQ-029 m_axis_tready toggled 0/1 every cycle during 5-beat packet -> exactly 5 data beats, stable outputs while stalled, tlast on beat 5 only.
REQ-030 rst_txclk pulsed at beat 2 of 4 -> next cycle tvalid=0, busy=0; next request from channel 0 granted first.
REQ-031 HDR_EN=0, single channel, two 2-beat packets -> 4 data beats with exactly one idle cycle between packets.
